// File: rtl/traffic_pkg.sv
// Shared lamp encodings, controller state enumeration and the all-red exit selector
// for the timed traffic-light controller.
package traffic_pkg;

  typedef logic [1:0] lamp_t;

  localparam lamp_t GREEN  = 2'b00;
  localparam lamp_t RED    = 2'b01;
  localparam lamp_t YELLOW = 2'b10;
  localparam lamp_t DARK   = 2'b11;

  // Four bits leave spare encodings so a corrupted state is detectable.
  typedef enum logic [3:0] {
    ES_GRN = 4'd0,
    ES_YEL = 4'd1,
    RED_A  = 4'd2,
    NS_GRN = 4'd3,
    NS_YEL = 4'd4,
    RED_B  = 4'd5,
    WALK   = 4'd6,
    FLASH  = 4'd7
  } tl_state_e;

  // Exit choice at an all-red boundary: flash beats pedestrian beats the opposite green.
  function automatic tl_state_e red_exit(input logic flash, input logic ped, input logic to_ns);
    if (flash) begin
      return FLASH;
    end else if (ped) begin
      return WALK;
    end else begin
      return to_ns ? NS_GRN : ES_GRN;
    end
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Dwell counter: clears on request, otherwise counts up; flags when the count
// reaches the terminal value supplied by the controller.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/traffic_light_timed.sv
// Two-way timed traffic-light controller with pedestrian walk phase and night flash mode.
// Lamps decode only from registered state, so they are glitch-free and safe-red by default.
module traffic_light_timed
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned WALK_CYC   = 5,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [1:0] es_light,
  output logic [1:0] ns_light,
  output logic       walk,
  output logic       ped_wait
);

  tl_state_e        state_q, state_d;
  logic             ped_wait_q, ped_wait_d;
  logic             dir_ns_q, dir_ns_d;
  logic             flash_ph_q, flash_ph_d;  // 0 = yellow half, 1 = dark half
  logic             start_q;
  logic             clr;
  logic             done;
  logic [CNT_W-1:0] term;

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (clr),
    .term_i (term),
    .done_o (done)
  );

  always_comb begin
    term = '0;
    case (state_q)
      ES_GRN, NS_GRN: term = CNT_W'(GREEN_CYC - 1);
      ES_YEL, NS_YEL: term = CNT_W'(YELLOW_CYC - 1);
      RED_A, RED_B:   term = CNT_W'(ALLRED_CYC - 1);
      WALK:           term = CNT_W'(WALK_CYC - 1);
      FLASH:          term = CNT_W'(FLASH_HALF - 1);
      default:        term = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dir_ns_d   = dir_ns_q;
    flash_ph_d = 1'b0;
    case (state_q)
      ES_GRN: if (done) state_d = ES_YEL;
      ES_YEL: if (done) state_d = RED_A;
      NS_GRN: if (done) state_d = NS_YEL;
      NS_YEL: if (done) state_d = RED_B;
      RED_A: begin
        if (done) begin
          state_d = red_exit(flash_mode, ped_wait_q, 1'b1);
          if (state_d == WALK) dir_ns_d = 1'b1;
        end
      end
      RED_B: begin
        if (done) begin
          state_d = red_exit(flash_mode, ped_wait_q, 1'b0);
          if (state_d == WALK) dir_ns_d = 1'b0;
        end
      end
      WALK: if (done) state_d = dir_ns_q ? NS_GRN : ES_GRN;
      FLASH: begin
        flash_ph_d = done ? ~flash_ph_q : flash_ph_q;
        if (!flash_mode) state_d = RED_B;
      end
      default: state_d = RED_B;
    endcase
    // First edge after reset release restarts the green dwell from zero.
    if (start_q) state_d = ES_GRN;

    clr = start_q || (state_d != state_q) || (state_q == FLASH && done);

    ped_wait_d = ped_wait_q;
    if (state_d == WALK || state_d == FLASH || state_q == WALK || state_q == FLASH) begin
      ped_wait_d = 1'b0;
    end else if (ped_req) begin
      ped_wait_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ES_GRN;
      ped_wait_q <= 1'b0;
      dir_ns_q   <= 1'b1;
      flash_ph_q <= 1'b0;
      start_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ped_wait_q <= ped_wait_d;
      dir_ns_q   <= dir_ns_d;
      flash_ph_q <= flash_ph_d;
      start_q    <= 1'b0;
    end
  end

  always_comb begin
    es_light = RED;
    ns_light = RED;
    walk     = 1'b0;
    case (state_q)
      ES_GRN: es_light = GREEN;
      ES_YEL: es_light = YELLOW;
      NS_GRN: ns_light = GREEN;
      NS_YEL: ns_light = YELLOW;
      WALK:   walk     = 1'b1;
      FLASH: begin
        es_light = flash_ph_q ? DARK : YELLOW;
        ns_light = flash_ph_q ? DARK : YELLOW;
      end
      default: ;
    endcase
  end

  assign ped_wait = ped_wait_q;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Directed bench for traffic_light_timed at default timing; cycle 0 is the first
// rising edge after reset release.
module tb_traffic_light_timed;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic [1:0] es_light, ns_light;
  logic       walk, ped_wait;

  int tests = 0;
  int fails = 0;
  int cyc = -1;

  traffic_light_timed #(
    .GREEN_CYC  (8),
    .YELLOW_CYC (3),
    .ALLRED_CYC (2),
    .WALK_CYC   (5),
    .FLASH_HALF (4),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ped_req    (ped_req),
    .flash_mode (flash_mode),
    .es_light   (es_light),
    .ns_light   (ns_light),
    .walk       (walk),
    .ped_wait   (ped_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    ped_req    = 1'b0;
    flash_mode = 1'b0;
    rst        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = -1;
  endtask

  task automatic test_reset();
    ped_req = 1'b1;
    rst     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (es_light !== GREEN) begin
      fails++; $display("FAIL reset_es: got %b, required %b", es_light, GREEN);
    end
    tests++;
    if (ns_light !== RED) begin
      fails++; $display("FAIL reset_ns: got %b, required %b", ns_light, RED);
    end
    tests++;
    if (walk !== 1'b0) begin
      fails++; $display("FAIL reset_walk: got %b, required 0", walk);
    end
    tests++;
    if (ped_wait !== 1'b0) begin
      fails++; $display("FAIL reset_ped_wait: got %b, required 0", ped_wait);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_free_run();
    logic [1:0] e_es, e_ns;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      tick();
      if (c <= 7)       begin e_es = GREEN;  e_ns = RED;    end
      else if (c <= 10) begin e_es = YELLOW; e_ns = RED;    end
      else if (c <= 12) begin e_es = RED;    e_ns = RED;    end
      else if (c <= 20) begin e_es = RED;    e_ns = GREEN;  end
      else if (c <= 23) begin e_es = RED;    e_ns = YELLOW; end
      else if (c <= 25) begin e_es = RED;    e_ns = RED;    end
      else              begin e_es = GREEN;  e_ns = RED;    end
      tests++;
      if (es_light !== e_es || ns_light !== e_ns || walk !== 1'b0) begin
        fails++;
        $display("FAIL free_run cyc %0d: es=%b ns=%b walk=%b, required es=%b ns=%b walk=0",
                 cyc, es_light, ns_light, walk, e_es, e_ns);
      end
    end
  endtask

  task automatic test_ped_pulse();
    logic e_pw, e_walk;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      tick();
      e_pw   = (c >= 4 && c <= 12);
      e_walk = (c >= 13 && c <= 17);
      tests++;
      if (ped_wait !== e_pw || walk !== e_walk) begin
        fails++;
        $display("FAIL ped_pulse cyc %0d: ped_wait=%b walk=%b, required ped_wait=%b walk=%b",
                 cyc, ped_wait, walk, e_pw, e_walk);
      end
      if (c == 15) begin
        tests++;
        if (es_light !== RED || ns_light !== RED) begin
          fails++;
          $display("FAIL ped_walk_lamps: es=%b ns=%b, required 01/01", es_light, ns_light);
        end
      end
      if (c == 18) begin
        tests++;
        if (es_light !== RED || ns_light !== GREEN) begin
          fails++;
          $display("FAIL ped_exit_ns_grn: es=%b ns=%b, required 01/00", es_light, ns_light);
        end
      end
      if (c == 3) ped_req = 1'b1;
      if (c == 4) ped_req = 1'b0;
    end
  endtask

  task automatic test_flash();
    logic [1:0] e_es, e_ns;
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      tick();
      if (c <= 7)       begin e_es = GREEN;  e_ns = RED;    end
      else if (c <= 10) begin e_es = YELLOW; e_ns = RED;    end
      else if (c <= 12) begin e_es = RED;    e_ns = RED;    end
      else if (c <= 16) begin e_es = YELLOW; e_ns = YELLOW; end
      else if (c <= 20) begin e_es = DARK;   e_ns = DARK;   end
      else              begin e_es = YELLOW; e_ns = YELLOW; end
      tests++;
      if (es_light !== e_es || ns_light !== e_ns || walk !== 1'b0) begin
        fails++;
        $display("FAIL flash cyc %0d: es=%b ns=%b walk=%b, required es=%b ns=%b walk=0",
                 cyc, es_light, ns_light, walk, e_es, e_ns);
      end
      if (c == 4) flash_mode = 1'b1;
    end
  endtask

  task automatic test_flash_exit();
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      tick();
      if (c >= 14 && c <= 18) begin
        tests++;
        if (ped_wait !== 1'b0) begin
          fails++; $display("FAIL flash_ped_wait cyc %0d: got %b, required 0", cyc, ped_wait);
        end
      end
      if (c == 19 || c == 20) begin
        tests++;
        if (es_light !== RED || ns_light !== RED) begin
          fails++;
          $display("FAIL flash_exit_red cyc %0d: es=%b ns=%b, required 01/01",
                   cyc, es_light, ns_light);
        end
      end
      if (c == 21) begin
        tests++;
        if (es_light !== GREEN || ns_light !== RED || ped_wait !== 1'b0) begin
          fails++;
          $display("FAIL flash_exit_es_grn: es=%b ns=%b ped_wait=%b, required 00/01 pw=0",
                   es_light, ns_light, ped_wait);
        end
      end
      if (c == 4) flash_mode = 1'b1;
      if (c == 13) ped_req = 1'b1;
      if (c == 18) begin
        flash_mode = 1'b0;
        ped_req    = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] e_es;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      tick();
      if (c == 14) ped_req = 1'b1;
    end
    ped_req = 1'b0;
    tests++;
    if (ns_light !== GREEN || ped_wait !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_state: ns=%b ped_wait=%b, required ns=00 ped_wait=1",
               ns_light, ped_wait);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (es_light !== GREEN || ns_light !== RED) begin
      fails++;
      $display("FAIL async_reset_lamps: es=%b ns=%b, required 00/01", es_light, ns_light);
    end
    tests++;
    if (walk !== 1'b0 || ped_wait !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_flags: walk=%b ped_wait=%b, required 0/0", walk, ped_wait);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc = -1;
    for (int c = 0; c <= 8; c++) begin
      tick();
      e_es = (c <= 7) ? GREEN : YELLOW;
      tests++;
      if (es_light !== e_es || ns_light !== RED) begin
        fails++;
        $display("FAIL restart cyc %0d: es=%b ns=%b, required es=%b ns=01",
                 cyc, es_light, ns_light, e_es);
      end
    end
  endtask

  task automatic test_ped_held();
    do_reset();
    for (int c = 0; c <= 31; c++) begin
      tick();
      if (c >= 13 && c <= 17) begin
        tests++;
        if (walk !== 1'b1 || ped_wait !== 1'b0) begin
          fails++;
          $display("FAIL held_walk cyc %0d: walk=%b ped_wait=%b, required 1/0",
                   cyc, walk, ped_wait);
        end
      end
      if (c == 18) begin
        tests++;
        if (walk !== 1'b0 || ns_light !== GREEN || ped_wait !== 1'b0) begin
          fails++;
          $display("FAIL held_exit: walk=%b ns=%b ped_wait=%b, required 0/00/0",
                   walk, ns_light, ped_wait);
        end
      end
      if (c == 19) begin
        tests++;
        if (ped_wait !== 1'b1) begin
          fails++; $display("FAIL held_relatch: ped_wait=%b, required 1", ped_wait);
        end
      end
      if (c == 31) begin
        tests++;
        if (walk !== 1'b1) begin
          fails++; $display("FAIL held_second_walk: walk=%b, required 1", walk);
        end
      end
      if (c == 1) ped_req = 1'b1;
    end
    ped_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_pulse();
    test_flash();
    test_flash_exit();
    test_async_reset();
    test_ped_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
